// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus definitions for the two-master memory bus arbiter: widths,
// FSM state encoding, arbitration modes, master indices and command payload.
package mem_bus_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WCNT_W = 16;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    localparam logic MST_M0 = 1'b0;
    localparam logic MST_M1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef struct packed {
        logic              we;
        logic              io;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the downstream memory port.
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    logic              m0_req, m0_we, m0_io, m0_ack, m0_err;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata, m0_rdata;
    logic              m1_req, m1_we, m1_io, m1_ack, m1_err;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata, m1_rdata;
    logic              db_re, db_we, db_io, db_ready;
    logic [ADDR_W-1:0] db_addr;
    logic [DATA_W-1:0] db_dataOut, db_dataIn;

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_io, m0_addr, m0_wdata,
        output m0_ack, m0_err, m0_rdata,
        input  m1_req, m1_we, m1_io, m1_addr, m1_wdata,
        output m1_ack, m1_err, m1_rdata,
        output db_re, db_we, db_io, db_addr, db_dataOut,
        input  db_ready, db_dataIn
    );

    // Environment side (masters plus downstream memory)
    modport master (
        output m0_req, m0_we, m0_io, m0_addr, m0_wdata,
        input  m0_ack, m0_err, m0_rdata,
        output m1_req, m1_we, m1_io, m1_addr, m1_wdata,
        input  m1_ack, m1_err, m1_rdata,
        input  db_re, db_we, db_io, db_addr, db_dataOut,
        output db_ready, db_dataIn
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way grant selection with a last-grant pointer; fixed priority or round-robin.
module rr_arbiter2
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ARB_MODE = ARB_RR
) (
    input  logic       clk,
    input  logic       res,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt_valid_c,
    output logic       gnt_idx_c
);

    logic last_q;

    always_comb begin
        gnt_valid_c = |req;
        gnt_idx_c   = MST_M0;
        if (ARB_MODE == ARB_FIXED) begin
            gnt_idx_c = req[0] ? MST_M0 : MST_M1;
        end else if (req == 2'b11) begin
            gnt_idx_c = ~last_q;
        end else begin
            gnt_idx_c = req[1] ? MST_M1 : MST_M0;
        end
    end

    // Reset to m1 so that m0 wins the first contested grant
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            last_q <= MST_M1;
        end else if (take) begin
            last_q <= gnt_idx_c;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter: grant, one-cycle command issue, completion
// wait with optional watchdog, and per-master read data registers.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ARB_MODE = ARB_RR,
    parameter int unsigned MAX_WAIT = 0
) (
    input  logic              clk,
    input  logic              res,
    mem_bus_arbiter_if.slave  bus
);

    localparam bit                WD_EN  = (MAX_WAIT != 0);
    localparam logic [WCNT_W-1:0] WD_LIM = WD_EN ? WCNT_W'(MAX_WAIT - 1) : '0;

    state_e              state_q, state_d;
    cmd_t                cmd_q, cmd_d, cmd_m0, cmd_m1;
    logic                gnt_q, gnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [1:0]          ack_q, ack_d, err_q, err_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                re_q, re_d, we_q, we_d, io_q, io_d;
    logic                take_c, gnt_valid_c, gnt_idx_c;
    logic [1:0]          req_c;

    assign req_c  = {bus.m1_req, bus.m0_req};
    assign cmd_m0 = '{we: bus.m0_we, io: bus.m0_io, addr: bus.m0_addr, wdata: bus.m0_wdata};
    assign cmd_m1 = '{we: bus.m1_we, io: bus.m1_io, addr: bus.m1_addr, wdata: bus.m1_wdata};

    rr_arbiter2 #(.ARB_MODE(ARB_MODE)) u_arb (
        .clk         (clk),
        .res         (res),
        .req         (req_c),
        .take        (take_c),
        .gnt_valid_c (gnt_valid_c),
        .gnt_idx_c   (gnt_idx_c)
    );

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        gnt_d    = gnt_q;
        wcnt_d   = wcnt_q;
        ack_d    = '0;
        err_d    = '0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        re_d     = 1'b0;
        we_d     = 1'b0;
        io_d     = 1'b0;
        take_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // No grant in an ack cycle: the acked master still holds req
                if (bus.db_ready && gnt_valid_c && (ack_q == 2'b00)) begin
                    take_c  = 1'b1;
                    gnt_d   = gnt_idx_c;
                    cmd_d   = (gnt_idx_c == MST_M1) ? cmd_m1 : cmd_m0;
                    re_d    = ~cmd_d.we;
                    we_d    = cmd_d.we;
                    io_d    = cmd_d.io;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wcnt_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.db_ready) begin
                    ack_d[gnt_q] = 1'b1;
                    if (!cmd_q.we) begin
                        if (gnt_q == MST_M1) rdata1_d = bus.db_dataIn;
                        else                 rdata0_d = bus.db_dataIn;
                    end
                    state_d = ST_IDLE;
                end else if (WD_EN && (wcnt_q == WD_LIM)) begin
                    ack_d[gnt_q] = 1'b1;
                    err_d[gnt_q] = 1'b1;
                    state_d      = ST_IDLE;
                end else if (wcnt_q != '1) begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            gnt_q    <= MST_M0;
            wcnt_q   <= '0;
            ack_q    <= '0;
            err_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            io_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            gnt_q    <= gnt_d;
            wcnt_q   <= wcnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            re_q     <= re_d;
            we_q     <= we_d;
            io_q     <= io_d;
        end
    end

    assign bus.m0_ack     = ack_q[0];
    assign bus.m1_ack     = ack_q[1];
    assign bus.m0_err     = err_q[0];
    assign bus.m1_err     = err_q[1];
    assign bus.m0_rdata   = rdata0_q;
    assign bus.m1_rdata   = rdata1_q;
    assign bus.db_re      = re_q;
    assign bus.db_we      = we_q;
    assign bus.db_io      = io_q;
    assign bus.db_addr    = cmd_q.addr;
    assign bus.db_dataOut = cmd_q.wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: round-robin arbiter with an 8-cycle watchdog and a
// fixed-priority arbiter without watchdog, driven and sampled on negedge.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        res;
    int          checks = 0;
    int          errors = 0;
    int          early;
    int          pulses;
    logic [31:0] ga;

    always #5 clk = ~clk;

    mem_bus_arbiter_if if_rr();
    mem_bus_arbiter_if if_fp();

    mem_bus_arbiter #(.ARB_MODE(ARB_RR), .MAX_WAIT(8)) dut_rr (
        .clk (clk),
        .res (res),
        .bus (if_rr.slave)
    );

    mem_bus_arbiter #(.ARB_MODE(ARB_FIXED), .MAX_WAIT(0)) dut_fp (
        .clk (clk),
        .res (res),
        .bus (if_fp.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next issued command and return its address
    task automatic next_grant(input bit on_rr, output logic [31:0] addr);
        bit found = 1'b0;
        addr = '0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (on_rr ? (if_rr.db_re | if_rr.db_we) : (if_fp.db_re | if_fp.db_we)) begin
                found = 1'b1;
                addr  = on_rr ? if_rr.db_addr : if_fp.db_addr;
            end
        end
        chk("grant_seen", 32'(found), 32'd1);
    endtask

    initial begin
        res = 1'b1;
        {if_rr.m0_req, if_rr.m0_we, if_rr.m0_io, if_rr.m1_req, if_rr.m1_we, if_rr.m1_io} = '0;
        {if_fp.m0_req, if_fp.m0_we, if_fp.m0_io, if_fp.m1_req, if_fp.m1_we, if_fp.m1_io} = '0;
        if_rr.m0_addr = '0; if_rr.m0_wdata = '0; if_rr.m1_addr = '0; if_rr.m1_wdata = '0;
        if_fp.m0_addr = '0; if_fp.m0_wdata = '0; if_fp.m1_addr = '0; if_fp.m1_wdata = '0;
        if_rr.db_ready = 1'b0; if_rr.db_dataIn = '0;
        if_fp.db_ready = 1'b0; if_fp.db_dataIn = '0;
        repeat (2) @(negedge clk);

        chk("rst_m0_ack",   32'(if_fp.m0_ack), 32'd0);
        chk("rst_m1_err",   32'(if_fp.m1_err), 32'd0);
        chk("rst_db_re",    32'(if_fp.db_re),  32'd0);
        chk("rst_db_we",    32'(if_rr.db_we),  32'd0);
        chk("rst_db_addr",  if_fp.db_addr,     32'h0);
        chk("rst_m0_rdata", if_fp.m0_rdata,    32'h0);

        // Release reset with both rr masters requesting but downstream busy
        res = 1'b0;
        if_fp.db_ready = 1'b1;
        if_rr.m0_addr = 32'h0000_0100; if_rr.m1_addr = 32'h0000_0200;
        if_rr.m0_req = 1'b1; if_rr.m1_req = 1'b1;
        if_rr.db_dataIn = 32'h1111_2222;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(if_rr.db_re | if_rr.db_we);
        end
        chk("no_grant_until_ready", 32'(pulses), 32'd0);
        if_rr.db_ready = 1'b1;

        // Round-robin order with both held
        next_grant(1'b1, ga); chk("rr_g1_m0", ga, 32'h0000_0100);
        @(negedge clk); @(negedge clk);
        chk("rr_ack_latency", 32'(if_rr.m0_ack), 32'd1);
        chk("rr_m1_no_ack",   32'(if_rr.m1_ack), 32'd0);
        chk("rr_m0_rdata",    if_rr.m0_rdata,    32'h1111_2222);
        next_grant(1'b1, ga); chk("rr_g2_m1", ga, 32'h0000_0200);
        next_grant(1'b1, ga); chk("rr_g3_m0", ga, 32'h0000_0100);
        next_grant(1'b1, ga); chk("rr_g4_m1", ga, 32'h0000_0200);
        if_rr.m0_req = 1'b0; if_rr.m1_req = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("req_drop_still_acks", 32'(if_rr.m1_ack), 32'd1);
        @(negedge clk); @(negedge clk);

        // Reset during WAIT aborts without ack
        if_rr.m1_req = 1'b1;
        next_grant(1'b1, ga); chk("pre_rst_grant_m1", ga, 32'h0000_0200);
        if_rr.db_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        res = 1'b1;
        #1;
        chk("rst_abort_ack",   32'(if_rr.m1_ack), 32'd0);
        chk("rst_abort_addr",  if_rr.db_addr,     32'h0);
        chk("rst_abort_rdata", if_rr.m1_rdata,    32'h0);
        @(negedge clk); @(negedge clk);
        chk("rst_hold_ack", 32'(if_rr.m1_ack), 32'd0);
        res = 1'b0;
        if_rr.m0_req = 1'b1;
        if_rr.db_ready = 1'b1;
        if_rr.db_dataIn = 32'h5555_AAAA;
        next_grant(1'b1, ga); chk("post_rst_m0_wins", ga, 32'h0000_0100);
        if_rr.m0_req = 1'b0; if_rr.m1_req = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("post_rst_ack",   32'(if_rr.m0_ack), 32'd1);
        chk("post_rst_rdata", if_rr.m0_rdata,    32'h5555_AAAA);
        @(negedge clk); @(negedge clk);

        // Watchdog: downstream never answers
        if_rr.m0_req = 1'b1;
        next_grant(1'b1, ga); chk("wd_grant", ga, 32'h0000_0100);
        if_rr.db_ready = 1'b0;
        if_rr.db_dataIn = 32'h7777_0000;
        early = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k < 9) early += int'(if_rr.m0_ack | if_rr.m0_err);
        end
        chk("wd_no_early_ack", 32'(early),        32'd0);
        chk("wd_ack",          32'(if_rr.m0_ack), 32'd1);
        chk("wd_err",          32'(if_rr.m0_err), 32'd1);
        chk("wd_rdata_kept",   if_rr.m0_rdata,    32'h5555_AAAA);
        if_rr.m0_req = 1'b0;
        if_rr.m1_req = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            pulses += int'(if_rr.db_re | if_rr.db_we);
        end
        chk("wd_hold_idle", 32'(pulses),       32'd0);
        chk("wd_err_pulse", 32'(if_rr.m0_err), 32'd0);
        if_rr.db_ready = 1'b1;

        // m1 held through ack; m0 arriving meanwhile is served first
        next_grant(1'b1, ga); chk("post_wd_grant_m1", ga, 32'h0000_0200);
        @(negedge clk);
        if_rr.m0_req = 1'b1;
        @(negedge clk);
        chk("held_m1_ack",   32'(if_rr.m1_ack), 32'd1);
        chk("held_m1_rdata", if_rr.m1_rdata,    32'h7777_0000);
        @(negedge clk);
        chk("no_grant_in_ack_cycle", 32'(if_rr.db_re | if_rr.db_we), 32'd0);
        next_grant(1'b1, ga); chk("interleaved_m0_first", ga, 32'h0000_0100);
        next_grant(1'b1, ga); chk("held_m1_second",       ga, 32'h0000_0200);
        if_rr.m0_req = 1'b0; if_rr.m1_req = 1'b0;
        repeat (3) @(negedge clk);

        // Long read with 20 busy cycles
        if_fp.m0_addr = 32'h0000_0010;
        if_fp.m0_req = 1'b1;
        next_grant(1'b0, ga); chk("long_rd_addr", ga, 32'h0000_0010);
        chk("long_rd_re", 32'(if_fp.db_re), 32'd1);
        pulses = 1;
        early = 0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 1) if_fp.db_ready = 1'b0;
            pulses += int'(if_fp.db_re);
            if (k < 22) early += int'(if_fp.m0_ack);
            if (k == 21) begin
                if_fp.db_ready = 1'b1;
                if_fp.db_dataIn = 32'hDEAD_BEEF;
            end
        end
        chk("long_rd_ack",      32'(if_fp.m0_ack), 32'd1);
        chk("long_rd_rdata",    if_fp.m0_rdata,    32'hDEAD_BEEF);
        chk("long_rd_no_early", 32'(early),        32'd0);
        chk("long_rd_one_re",   32'(pulses),       32'd1);
        if_fp.m0_req = 1'b0;
        @(negedge clk); @(negedge clk);

        // IO write the downstream ignores
        if_fp.db_dataIn = 32'hCAFE_F00D;
        if_fp.m1_addr = 32'hA000_0005; if_fp.m1_wdata = 32'h1234_5678;
        if_fp.m1_we = 1'b1; if_fp.m1_io = 1'b1; if_fp.m1_req = 1'b1;
        next_grant(1'b0, ga); chk("io_wr_addr", ga, 32'hA000_0005);
        chk("io_wr_we",    32'(if_fp.db_we), 32'd1);
        chk("io_wr_io",    32'(if_fp.db_io), 32'd1);
        chk("io_wr_re",    32'(if_fp.db_re), 32'd0);
        chk("io_wr_wdata", if_fp.db_dataOut, 32'h1234_5678);
        pulses = 1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            pulses += int'(if_fp.db_we);
            if (k == 2) begin
                chk("io_wr_ack",   32'(if_fp.m1_ack), 32'd1);
                chk("io_wr_rdata", if_fp.m1_rdata,    32'h0);
                if_fp.m1_req = 1'b0; if_fp.m1_we = 1'b0; if_fp.m1_io = 1'b0;
            end
        end
        chk("io_wr_one_we", 32'(pulses), 32'd1);

        // Fixed priority: m0 only while it keeps requesting
        if_fp.m0_addr = 32'h0000_0020; if_fp.m1_addr = 32'h0000_0030;
        if_fp.m0_req = 1'b1; if_fp.m1_req = 1'b1;
        next_grant(1'b0, ga); chk("fp_g1_m0", ga, 32'h0000_0020);
        next_grant(1'b0, ga); chk("fp_g2_m0", ga, 32'h0000_0020);
        next_grant(1'b0, ga); chk("fp_g3_m0", ga, 32'h0000_0020);
        if_fp.m0_req = 1'b0;
        next_grant(1'b0, ga); chk("fp_g4_m1", ga, 32'h0000_0030);
        if_fp.m1_req = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ARB_MODE, default 1: 0 = fixed priority (m0 wins), 1 = round-robin.
REQ-002 Parameter MAX_WAIT, default 0: watchdog limit in cycles for WAIT; 0 disables the watchdog.
REQ-003 clk  in  1  sole clock; all state changes on posedge.
REQ-004 res  in  1  asynchronous, active-high reset.
REQ-005 mN_req  in  1  (N = 0 instruction fetch, N = 1 data) request, level, held until mN_ack.
REQ-006 mN_we / mN_io  in  1 each  write / IO-space qualifiers; read when mN_we = 0.
REQ-007 mN_addr / mN_wdata  in  32 each  address / write data.
REQ-008 mN_ack  out  1  one-cycle completion pulse.
REQ-009 mN_rdata  out  32  read data, valid from the mN_ack cycle until the next read completion for that master.
REQ-010 mN_err  out  1  one-cycle pulse with mN_ack when the watchdog expired.
REQ-011 db_re, db_we, db_io  out  1 each  downstream memory-interface strobes.
REQ-012 db_addr, db_dataOut  out  32 each  downstream address / write data.
REQ-013 db_ready  in  1  downstream idle flag; db_dataIn  in  32  downstream read data.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-015 In IDLE with any mN_req high and db_ready high, the block SHALL grant one master, latch its we/io/addr/wdata into the command registers, and go to ISSUE.
REQ-016 Arbitration: ARB_MODE 0 grants m0 whenever m0_req is high; ARB_MODE 1 grants the master not served last when both request, and updates the last-grant pointer on every grant.
REQ-017 In ISSUE (exactly 1 cycle) the block SHALL drive the latched command: db_re = ~we, db_we = we, db_io = io, db_addr/db_dataOut = latched values.
REQ-018 In ISSUE the FSM SHALL always go to WAIT.
REQ-019 In IDLE and WAIT, db_re, db_we and db_io SHALL be 0, so the downstream never re-issues.
REQ-020 db_addr and db_dataOut SHALL hold the latched values outside ISSUE.
REQ-021 In WAIT with db_ready high, the block SHALL pulse the granted mN_ack and go to IDLE.
REQ-022 On a read completion (REQ-021), the block SHALL latch db_dataIn into mN_rdata in that cycle.
REQ-023 A command the downstream ignores (db_ready never drops, e.g. IO to an unmapped address) SHALL complete at the first WAIT cycle, giving latency 2 cycles from grant to ack.
REQ-024 Latency: grant edge -> ISSUE, 1 cycle; ack at the first WAIT cycle with db_ready high.
REQ-025 An mN_req high in its own ack cycle SHALL NOT be granted.
REQ-026 A master may present a new request from the cycle after ack; it is then arbitrated normally, with the earliest grant at the next IDLE evaluation.
REQ-027 Requests arriving while not in IDLE SHALL wait; a requester is never dropped.
REQ-028 Under ARB_MODE 1, no master SHALL wait more than one other transaction.
REQ-029 Watchdog: if MAX_WAIT > 0 and WAIT lasts MAX_WAIT cycles, the block SHALL pulse mN_ack together with mN_err, leave mN_rdata unchanged, and return to IDLE.
REQ-030 After a watchdog expiry, the FSM SHALL stay in IDLE until db_ready is high before any new grant.
REQ-031 The wait counter SHALL be 16 bits, clear on ISSUE, and saturate, never wrapping.
REQ-032 mN_req dropping before its ack SHALL NOT abort an issued command; the ack still pulses.

Reset
REQ-033 res SHALL force state IDLE, all acks/errs/strobes 0, command and rdata registers 0, last-grant pointer = m1 (so m0 wins first), and the wait counter 0.
REQ-034 res asserted mid-transaction SHALL abort it with no ack.
REQ-035 The first grant after res deasserts SHALL wait for db_ready high.

Structure
REQ-036 The state encodings, the ARB_MODE values and the master index constants SHALL live in the shared bus header alongside the data-bus definitions.
REQ-037 A single sub-module, rr_arbiter2, SHALL contain the 2-way grant/pointer logic.
REQ-038 The FSM, command latch, watchdog and rdata registers SHALL stay in mem_bus_arbiter.

Verification
REQ-039 m0 read addr 0x0000_0010, downstream returns 0xDEAD_BEEF after 20 busy cycles -> one db_re pulse, m0_ack after 22 cycles, m0_rdata = 0xDEAD_BEEF.
REQ-040 m0 and m1 request in the same cycle, ARB_MODE 1, both held -> grant order m0, m1, m0, m1; ARB_MODE 0 -> m0 only while m0_req stays high.
REQ-041 m1 write io = 1, addr 0xA000_0005, db_ready never drops -> m1_ack 2 cycles after grant, db_we high exactly 1 cycle, m1_rdata unchanged.
REQ-042 MAX_WAIT = 8, db_ready held low -> m0_ack and m0_err pulse together on the 8th WAIT cycle; no new grant until db_ready returns high.
REQ-043 res pulsed during WAIT -> no ack, all outputs 0; after release, m0 wins a simultaneous request.
REQ-044 m1_req held high through its ack -> a second m1 transaction is granted only after the return to IDLE, and an interleaved m0 request is served first under ARB_MODE 1.
